// File: rtl/timer_cmd_pkg.sv
// Shared types and constants for the serial command initiator that drives
// the advanced_timer_simple input side.
package timer_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2,
        ACK       = 2'd3
    } cmd_state_t;

    localparam int PATTERN_W       = 4;
    localparam int DELAY_W         = 4;
    localparam int CMD_BITS        = 8;
    localparam int CYCLES_PER_UNIT = 1000;

    localparam logic [PATTERN_W-1:0] PATTERN_DEFAULT = 4'b1101;

    // Command word as it goes on the wire: pattern first, then delay, MSB first.
    function automatic logic [CMD_BITS-1:0] build_cmd(
        input logic [PATTERN_W-1:0] pattern,
        input logic [DELAY_W-1:0]   dly
    );
        build_cmd = {pattern, dly};
    endfunction

endpackage

// File: rtl/piso_shift8.sv
// 8-bit parallel-load, MSB-first shift register with a bits-remaining counter;
// done is high while the final bit is the one on the line.
module piso_shift8
    import timer_cmd_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                shift,
    input  logic [CMD_BITS-1:0] din,
    output logic                next_bit,
    output logic                done
);

    localparam int              CNT_W    = $clog2(CMD_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CMD_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CMD_BITS-1:0] sh_r;
    logic [CNT_W-1:0]    cnt_r;

    // Shift register and remaining-bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_r  <= {CMD_BITS{1'b0}};
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            sh_r  <= din;
            cnt_r <= CNT_LAST;
        end else if (shift) begin
            sh_r  <= {sh_r[CMD_BITS-2:0], 1'b0};
            cnt_r <= (cnt_r == CNT_ZERO) ? CNT_ZERO : (cnt_r - CNT_ONE);
        end else begin
            sh_r  <= sh_r;
            cnt_r <= cnt_r;
        end
    end

    // The bit that becomes the MSB after the next shift, so the top can register it.
    assign next_bit = sh_r[CMD_BITS-2];
    assign done     = (cnt_r == CNT_ZERO);

endmodule

// File: rtl/timer_cmd_sender.sv
// Command initiator for advanced_timer_simple: sends pattern + delay serially,
// waits for done, acknowledges it and reports wait length or timeout.
module timer_cmd_sender
    import timer_cmd_pkg::*;
#(
    parameter logic [PATTERN_W-1:0] PATTERN        = PATTERN_DEFAULT,
    parameter int                   TIMEOUT_CYCLES = 20000,
    parameter int                   WCNT_W         = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DELAY_W-1:0] delay,
    output logic               ready,
    output logic               data,
    input  logic               done_in,
    output logic               ack,
    output logic               complete,
    output logic               timeout_err,
    output logic [WCNT_W-1:0]  wait_cycles
);

    localparam logic [WCNT_W-1:0] WCNT_ZERO = {WCNT_W{1'b0}};
    localparam logic [WCNT_W-1:0] WCNT_ONE  = {{(WCNT_W-1){1'b0}}, 1'b1};
    localparam logic [WCNT_W-1:0] WCNT_MAX  = {WCNT_W{1'b1}};
    localparam logic [WCNT_W-1:0] TMO_LAST  = WCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WCNT_W-1:0] TMO_VAL   = WCNT_W'(TIMEOUT_CYCLES);

    cmd_state_t          state_r, state_s;
    logic                data_r, data_s;
    logic                ack_r, ack_s;
    logic                complete_r, complete_s;
    logic                tmo_r, tmo_s;
    logic                ready_r, ready_s;
    logic [WCNT_W-1:0]   wcnt_r, wcnt_s;
    logic [WCNT_W-1:0]   wcyc_r, wcyc_s;
    logic [CMD_BITS-1:0] cmd_s;
    logic                load_s, shift_s;
    logic                piso_next_s, piso_done_s;

    assign cmd_s = build_cmd(PATTERN, delay);

    piso_shift8 u_piso (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .shift    (shift_s),
        .din      (cmd_s),
        .next_bit (piso_next_s),
        .done     (piso_done_s)
    );

    // Next-state and next-output decode; data is precomputed so it leaves a flop.
    always_comb begin
        state_s    = state_r;
        data_s     = 1'b0;
        ack_s      = 1'b0;
        complete_s = 1'b0;
        tmo_s      = tmo_r;
        wcnt_s     = wcnt_r;
        wcyc_s     = wcyc_r;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s  = 1'b1;
                    data_s  = cmd_s[CMD_BITS-1];
                    tmo_s   = 1'b0;
                    state_s = SEND;
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                shift_s = 1'b1;
                if (piso_done_s) begin
                    wcnt_s  = WCNT_ZERO;
                    state_s = WAIT_DONE;
                end else begin
                    data_s  = piso_next_s;
                end
            end
            WAIT_DONE: begin
                wcnt_s = (wcnt_r == WCNT_MAX) ? WCNT_MAX : (wcnt_r + WCNT_ONE);
                // done_in takes priority over a coincident timeout.
                if (done_in) begin
                    ack_s      = 1'b1;
                    complete_s = 1'b1;
                    wcyc_s     = wcnt_r;
                    state_s    = ACK;
                end else if (wcnt_r == TMO_LAST) begin
                    tmo_s   = 1'b1;
                    wcyc_s  = TMO_VAL;
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_DONE;
                end
            end
            ACK: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        ready_s = (state_s == IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            data_r     <= 1'b0;
            ack_r      <= 1'b0;
            complete_r <= 1'b0;
            tmo_r      <= 1'b0;
            ready_r    <= 1'b1;
            wcnt_r     <= WCNT_ZERO;
            wcyc_r     <= WCNT_ZERO;
        end else begin
            state_r    <= state_s;
            data_r     <= data_s;
            ack_r      <= ack_s;
            complete_r <= complete_s;
            tmo_r      <= tmo_s;
            ready_r    <= ready_s;
            wcnt_r     <= wcnt_s;
            wcyc_r     <= wcyc_s;
        end
    end

    assign ready       = ready_r;
    assign data        = data_r;
    assign ack         = ack_r;
    assign complete    = complete_r;
    assign timeout_err = tmo_r;
    assign wait_cycles = wcyc_r;

endmodule
